// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer for 8 requesters.
// Produces a registered index + valid strobe for a 3-to-8 decoder. Each grant
// is held until done, request drop, or the optional MAX_HOLD limit. The strobe
// always drops for at least one cycle between grants.
module rr_grant_sequencer #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       hold_timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Terminal hold count; unused when MAX_HOLD is 0.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [2:0]        last_ptr;

  logic [2:0]        winner;
  logic [2:0]        cand;
  logic              found;
  logic              exit_done;
  logic              exit_drop;
  logic              exit_limit;

  // Rotating priority search: start one past the last owner, last owner scanned last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      cand = last_ptr + 3'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Release conditions for the current owner.
  always_comb begin
    exit_done  = done;
    exit_drop  = ~req[grant_idx];
    exit_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  end

  // Grant state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant_idx    <= '0;
      grant_valid  <= 1'b0;
      hold_timeout <= 1'b0;
      hold_cnt     <= '0;
      last_ptr     <= '1;
    end else begin
      hold_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_idx   <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (exit_done || exit_drop || exit_limit) begin
            grant_valid  <= 1'b0;
            last_ptr     <= grant_idx;
            state        <= IDLE;
            hold_timeout <= exit_limit && !exit_done && !exit_drop;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
